// File: rtl/i2c_temp_slave.sv
// I2C target modelling an ADT7420-style temperature sensor: 16-byte register map, auto-increment pointer, open-drain SDA.
// Latency: SDA changes HOLD_CYC clk cycles after the synchronized SCL fall; alert flags are registered one cycle after temp_in.
// Backpressure: none; the bus master paces every transfer through SCL, and the slave never stretches the clock.
//
// Ports: clk/rst (async active-low), scl in, sda open-drain inout, temp_in (signed, 1/128 C LSB),
//        alert_high/alert_low/crit registered threshold flags, busy (START..STOP).
// Build option: define TEMP_SNAPSHOT_EN to return a coherent temp_in MSB/LSB pair across reads of 0x00 then 0x01.
module i2c_temp_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h48,
    parameter int         SYNC_STAGES = 2,
    parameter int         HOLD_CYC    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    input  logic [15:0] temp_in,
    output logic        alert_high,
    output logic        alert_low,
    output logic        crit,
    output logic        busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_t;

    localparam logic [7:0] HOLD_W = 8'(HOLD_CYC);

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_prev_q, sda_prev_q;
    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  sh_q, sh_d;          // bit 7 of a byte is consumed/driven directly
    logic [3:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        oe_q, oe_d;          // 1 = pull sda low
    logic        pend_q, pend_d;      // sda drive value waiting for the hold timer
    logic [7:0]  hold_q, hold_d;
    logic        busy_q, busy_d;
    logic        wr_en, load;
    logic [7:0]  rx_byte, rd_byte;
    logic [7:0]  reg_q [16];
    logic        alert_high_q, alert_low_q, crit_q;
    logic [7:0]  snap_q;

    assign sda = oe_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {sh_q, sda_s};

    // Byte presented for the current pointer; 0x00-0x02 are live views, not storage.
    always_comb begin
        rd_byte = reg_q[ptr_q];
        case (ptr_q)
            4'h0: rd_byte = temp_in[15:8];
`ifdef TEMP_SNAPSHOT_EN
            4'h1: rd_byte = snap_q;
`else
            4'h1: rd_byte = temp_in[7:0];
`endif
            4'h2: rd_byte = {crit_q, alert_high_q, alert_low_q, 5'b0};
            default: ;
        endcase
    end

    // Next state. In the ACK states cnt 8 means "ACK bit not yet clocked", 9 means "ACK bit clocked".
    always_comb begin
        state_d = state_q; cnt_d = cnt_q; sh_d = sh_q; ptr_d = ptr_q; rw_d = rw_q;
        oe_d = oe_q; pend_d = pend_q; hold_d = hold_q; busy_d = busy_q;
        wr_en = 1'b0; load = 1'b0;

        if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
            if (hold_q == 8'd1) oe_d = pend_q;
        end

        if (stop_det) begin
            state_d = S_IDLE; oe_d = 1'b0; hold_d = 8'd0; busy_d = 1'b0;
        end else if (start_det) begin
            state_d = S_DEV_ADDR; cnt_d = 4'd0; oe_d = 1'b0; hold_d = 8'd0; busy_d = 1'b1;
        end else begin
            case (state_q)
                S_DEV_ADDR, S_PTR, S_WR_DATA: begin
                    if (scl_rise) begin
                        sh_d  = rx_byte[6:0];
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (state_q == S_DEV_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_d = S_ADDR_ACK;
                                    rw_d    = rx_byte[0];
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end else if (state_q == S_PTR) begin
                                ptr_d   = rx_byte[3:0];
                                state_d = S_PTR_ACK;
                            end else begin
                                wr_en   = 1'b1;
                                ptr_d   = ptr_q + 4'd1;
                                state_d = S_WR_ACK;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                    if (scl_rise) begin
                        cnt_d = 4'd9;
                    end else if (scl_fall) begin
                        hold_d = HOLD_W;
                        if (cnt_q == 4'd8) begin
                            pend_d = 1'b1;
                        end else begin
                            cnt_d = 4'd0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_d = S_RD_DATA;
                                load    = 1'b1;
                                sh_d    = rd_byte[6:0];
                                pend_d  = ~rd_byte[7];
                            end else begin
                                pend_d  = 1'b0;
                                state_d = (state_q == S_ADDR_ACK) ? S_PTR : S_WR_DATA;
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) state_d = S_RD_ACK;
                    end else if (scl_fall) begin
                        sh_d   = {sh_q[5:0], 1'b0};
                        pend_d = ~sh_q[6];
                        hold_d = HOLD_W;
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr_q + 4'd1;
                        if (sda_s) state_d = S_WAIT_STOP;
                        else       cnt_d   = 4'd9;
                    end else if (scl_fall) begin
                        hold_d = HOLD_W;
                        if (cnt_q == 4'd8) begin
                            pend_d = 1'b0;  // hand sda to the master for its ACK
                        end else begin
                            cnt_d   = 4'd0;
                            state_d = S_RD_DATA;
                            load    = 1'b1;
                            sh_d    = rd_byte[6:0];
                            pend_d  = ~rd_byte[7];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE; cnt_q <= 4'd0; sh_q <= 7'd0; ptr_q <= 4'd0; rw_q <= 1'b0;
            oe_q <= 1'b0; pend_q <= 1'b0; hold_q <= 8'd0; busy_q <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; sh_q <= sh_d; ptr_q <= ptr_d; rw_q <= rw_d;
            oe_q <= oe_d; pend_q <= pend_d; hold_q <= hold_d; busy_q <= busy_d;
        end
    end

    // Register file; 0x00-0x02 and the ID at 0x0B are never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) reg_q[i] <= 8'h00;
            reg_q[4]  <= 8'h20;
            reg_q[6]  <= 8'h05;
            reg_q[8]  <= 8'h49;
            reg_q[9]  <= 8'h80;
            reg_q[11] <= 8'hCB;
        end else if (wr_en && ptr_q >= 4'h3 && ptr_q != 4'hB) begin
            reg_q[ptr_q] <= rx_byte;
        end
    end

    // Only the LSB needs holding: the MSB is sent in the same cycle the pair is captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       snap_q <= 8'h00;
        else if (load && ptr_q == 4'h0) snap_q <= temp_in[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alert_high_q <= 1'b0;
            alert_low_q  <= 1'b0;
            crit_q       <= 1'b0;
        end else begin
            alert_high_q <= $signed(temp_in) >  $signed({reg_q[4], reg_q[5]});
            alert_low_q  <= $signed(temp_in) <  $signed({reg_q[6], reg_q[7]});
            crit_q       <= $signed(temp_in) >= $signed({reg_q[8], reg_q[9]});
        end
    end

    assign alert_high = alert_high_q;
    assign alert_low  = alert_low_q;
    assign crit       = crit_q;
    assign busy       = busy_q;
endmodule
